pipelined_shifter: RTL

- Parametrised, fully pipelined shift unit for the MIPS datapath. Generalises the fixed constant left-shift to a variable shift amount and four modes: logical left, logical right, arithmetic right, rotate right.
- Sits behind ID/EX. Serves SLL/SRL/SRA/SLLV/SRLV/SRAV and rotate.
- Uses a valid/ready handshake, a pass-through destination tag and a pipeline flush for branch/exception squash.

---
 rtl/pipelined_shifter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pipelined_shifter.sv
// Variable-amount shift unit: one pipeline stage per shift-amount bit, with valid/ready
// flow control, a pass-through tag and a squash input.
module pipelined_shifter #(
    parameter  int unsigned width      = 32,
    parameter  int unsigned tagWidth   = 5,
    localparam int unsigned shamtWidth = $clog2(width)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [width-1:0]      in_data,
    input  logic [shamtWidth-1:0] in_shamt,
    input  logic [1:0]            in_op,
    input  logic [tagWidth-1:0]   in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [width-1:0]      out_data,
    output logic [tagWidth-1:0]   out_tag
);

    localparam int unsigned n_stages = shamtWidth;

    localparam logic [1:0] op_sll = 2'b00;
    localparam logic [1:0] op_srl = 2'b01;
    localparam logic [1:0] op_sra = 2'b10;

    // Op and remaining shamt are only needed by the stage that follows, so the last stage has none.
    logic [n_stages-1:0]   valid_q, valid_d;
    logic [n_stages-1:0]   load;
    logic [width-1:0]      data_q  [n_stages];
    logic [width-1:0]      data_d  [n_stages];
    logic [tagWidth-1:0]   tag_q   [n_stages];
    logic [tagWidth-1:0]   tag_d   [n_stages];
    logic [1:0]            op_q    [n_stages-1];
    logic [1:0]            op_d    [n_stages-1];
    logic [shamtWidth-1:0] shamt_q [n_stages-1];
    logic [shamtWidth-1:0] shamt_d [n_stages-1];
    logic                  in_ready_c;

    // Shift by 2^k when enabled; SRA fill is the current MSB, which is still the original sign.
    function automatic logic [width-1:0] shift_stage(input logic [width-1:0] d,
                                                     input logic [1:0]       op,
                                                     input logic             en,
                                                     input int unsigned      k);
        int unsigned      amt;
        logic [width-1:0] r;
        amt = 32'd1 << k;
        r   = d;
        if (en) begin
            case (op)
                op_sll:  r = d << amt;
                op_srl:  r = d >> amt;
                op_sra:  r = width'($signed(d) >>> amt);
                default: r = (d >> amt) | (d << (width - amt));
            endcase
        end
        return r;
    endfunction

    // Load chain ripples back from the consumer; stage data advances only on load.
    always_comb begin
        logic take;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        op_d    = op_q;
        shamt_d = shamt_q;
        load    = '0;

        take = out_ready;
        for (int k = int'(n_stages) - 1; k >= 0; k--) begin
            load[k] = !valid_q[k] || take;
            take    = load[k];
        end
        in_ready_c = load[0] && !flush && rst_n;

        if (load[0]) begin
            valid_d[0] = in_valid && in_ready_c;
            data_d[0]  = shift_stage(in_data, in_op, in_shamt[0], 0);
            tag_d[0]   = in_tag;
            op_d[0]    = in_op;
            shamt_d[0] = in_shamt >> 1;
        end

        for (int unsigned k = 1; k + 1 < n_stages; k++) begin
            if (load[k]) begin
                valid_d[k] = valid_q[k-1];
                data_d[k]  = shift_stage(data_q[k-1], op_q[k-1], shamt_q[k-1][0], k);
                tag_d[k]   = tag_q[k-1];
                op_d[k]    = op_q[k-1];
                shamt_d[k] = shamt_q[k-1] >> 1;
            end
        end

        if (load[n_stages-1]) begin
            valid_d[n_stages-1] = valid_q[n_stages-2];
            data_d[n_stages-1]  = shift_stage(data_q[n_stages-2], op_q[n_stages-2],
                                              shamt_q[n_stages-2][0], n_stages - 1);
            tag_d[n_stages-1]   = tag_q[n_stages-2];
        end

        if (flush) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < int'(n_stages); k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
            for (int k = 0; k < int'(n_stages) - 1; k++) begin
                op_q[k]    <= '0;
                shamt_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            op_q    <= op_d;
            shamt_q <= shamt_d;
        end
    end

    assign in_ready  = in_ready_c;
    assign out_valid = valid_q[n_stages-1];
    assign out_data  = data_q[n_stages-1];
    assign out_tag   = tag_q[n_stages-1];

endmodule
